// File: rtl/dcache_responder.sv
// dcache_responder
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// Word loads and stores that hit complete in the cycle they are presented.
// A miss stalls the pipeline. If the victim line is dirty it is written back
// first, then the requested line is filled. After the fill the request is
// evaluated again in IDLE as a hit, so a store miss merges its word into the
// freshly filled line.
//
// Optional feature: define DCACHE_STATS_EN to add saturating hit_cnt and
// miss_cnt outputs.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   cpu_rd     load request
//   cpu_wr     store request (wins when both are high)
//   cpu_addr   word address {tag, index, offset[1:0]}
//   cpu_wdata  store data
//   cpu_rdata  load data, combinational on a hit, 0 otherwise
//   cpu_stall  request cannot complete this cycle
//   mem_rd     line fill request
//   mem_wr     line writeback request
//   mem_addr   line address {tag, index}
//   mem_wdata  victim line, word 0 in [15:0]
//   mem_rdata  fill line, word 0 in [15:0]
//   mem_rdy    one-cycle completion pulse for mem_rd / mem_wr
//   hit_cnt    (DCACHE_STATS_EN) first-evaluation hits, saturating
//   miss_cnt   (DCACHE_STATS_EN) misses, saturating
module dcache_responder #(
  parameter int INDEX_BITS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [13:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_rdy
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
`endif
);

  localparam int TAG_BITS = 16 - 2 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WB   = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;

  function automatic logic [15:0] word_sel(input logic [63:0] line,
                                           input logic [1:0]  off);
    logic [15:0] w;
    case (off)
      2'd0:    w = line[15:0];
      2'd1:    w = line[31:16];
      2'd2:    w = line[47:32];
      default: w = line[63:48];
    endcase
    return w;
  endfunction

  function automatic logic [63:0] word_merge(input logic [63:0] line,
                                             input logic [1:0]  off,
                                             input logic [15:0] w);
    logic [63:0] r;
    r = line;
    case (off)
      2'd0:    r[15:0]  = w;
      2'd1:    r[31:16] = w;
      2'd2:    r[47:32] = w;
      default: r[63:48] = w;
    endcase
    return r;
  endfunction

  // Request decode
  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] req_idx;
  logic [1:0]            req_off;
  logic                  req_vld;
  logic                  hit;

  // Control state
  logic [1:0]            state_q, state_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic [LINES-1:0]      dirty_q, dirty_d;
  // Index/tag latched at miss detection; the miss is served from these.
  logic [INDEX_BITS-1:0] lidx_q, lidx_d;
  logic [TAG_BITS-1:0]   ltag_q, ltag_d;

  // Storage arrays (not reset; guarded by valid)
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [63:0]           data_q [LINES];

  logic                  store_hit;
  logic                  fill_done;

  assign req_tag = cpu_addr[15:2+INDEX_BITS];
  assign req_idx = cpu_addr[1+INDEX_BITS:2];
  assign req_off = cpu_addr[1:0];
  assign req_vld = cpu_rd | cpu_wr;
  assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    dirty_d   = dirty_q;
    lidx_d    = lidx_q;
    ltag_d    = ltag_q;
    cpu_rdata = 16'h0000;
    cpu_stall = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 14'h0000;
    mem_wdata = 64'h0;
    store_hit = 1'b0;
    fill_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_vld) begin
          if (hit) begin
            if (cpu_wr) begin
              store_hit        = 1'b1;
              dirty_d[req_idx] = 1'b1;
            end else begin
              cpu_rdata = word_sel(data_q[req_idx], req_off);
            end
          end else begin
            cpu_stall = 1'b1;
            lidx_d    = req_idx;
            ltag_d    = req_tag;
            if (valid_q[req_idx] && dirty_q[req_idx]) begin
              state_d = S_WB;
            end else begin
              state_d = S_FILL;
            end
          end
        end
      end
      S_WB: begin
        // Victim tag/data do not change while here, so outputs stay stable.
        cpu_stall = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = {tag_q[lidx_q], lidx_q};
        mem_wdata = data_q[lidx_q];
        if (mem_rdy) begin
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        cpu_stall = 1'b1;
        mem_rd    = 1'b1;
        mem_addr  = {ltag_q, lidx_q};
        if (mem_rdy) begin
          fill_done       = 1'b1;
          valid_d[lidx_q] = 1'b1;
          dirty_d[lidx_q] = 1'b0;
          state_d         = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      lidx_q  <= '0;
      ltag_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      lidx_q  <= lidx_d;
      ltag_q  <= ltag_d;
    end
  end

  always_ff @(posedge clk) begin
    if (store_hit) begin
      data_q[req_idx] <= word_merge(data_q[req_idx], req_off, cpu_wdata);
    end
    if (fill_done) begin
      data_q[lidx_q] <= mem_rdata;
      tag_q[lidx_q]  <= ltag_q;
    end
  end

`ifdef DCACHE_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;
  // High in the IDLE cycle right after a fill, where the stalled request
  // completes as a hit that must not be counted.
  logic        refill_q;
  logic        first_hit;
  logic        miss_evt;

  assign first_hit = (state_q == S_IDLE) && req_vld && hit && !refill_q;
  assign miss_evt  = (state_q == S_IDLE) && req_vld && !hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= 16'h0000;
      miss_cnt_q <= 16'h0000;
      refill_q   <= 1'b0;
    end else begin
      refill_q <= fill_done;
      if (first_hit) begin
        hit_cnt_q <= sat_inc(hit_cnt_q);
      end
      if (miss_evt) begin
        miss_cnt_q <= sat_inc(miss_cnt_q);
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_responder.sv
module tb_dcache_responder;

  logic        clk;
  logic        rst_n;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_rd;
  logic        mem_wr;
  logic [13:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = 64'h0;
  logic        mem_rdy   = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  dcache_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_rdy   (mem_rdy)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  int          lat = 1;
  int          rsp_cnt = 0;
  int          fill_total = 0;
  int          wb_total = 0;
  int          both_cnt = 0;
  logic [13:0] fill_last_addr = 14'h0;
  logic [13:0] wb_last_addr = 14'h0;
  logic [63:0] wb_last_data = 64'h0;
  logic [63:0] wb_mem [16384];
  bit          wb_has [16384];

  function automatic logic [63:0] base_line(input logic [13:0] a);
    case (a)
      14'h0010: return 64'hDDDD_CCCC_BBBB_AAAA;
      14'h0050: return 64'h4444_3333_2222_1111;
      14'h0080: return 64'h8888_7777_6666_5555;
      14'h0001: return 64'h1D03_1D02_1D01_1D00;
      default:  return 64'h0;
    endcase
  endfunction

  // Responder: mem_rdy pulses in the lat-th cycle of each transaction.
  always @(negedge clk) begin
    mem_rdata = wb_has[mem_addr] ? wb_mem[mem_addr] : base_line(mem_addr);
    if (!(mem_rd || mem_wr)) begin
      rsp_cnt = 0;
      mem_rdy = 1'b0;
    end else begin
      rsp_cnt = mem_rdy ? 1 : rsp_cnt + 1;
      mem_rdy = (rsp_cnt >= lat);
    end
  end

  always @(posedge clk) begin
    if (mem_rd && mem_wr) both_cnt <= both_cnt + 1;
    if (rst_n && mem_rdy && mem_wr) begin
      wb_total             <= wb_total + 1;
      wb_last_addr         <= mem_addr;
      wb_last_data         <= mem_wdata;
      wb_mem[mem_addr]     <= mem_wdata;
      wb_has[mem_addr]     <= 1'b1;
    end
    if (rst_n && mem_rdy && mem_rd) begin
      fill_total     <= fill_total + 1;
      fill_last_addr <= mem_addr;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          lat;
    int          exp_stall;
    logic        chk_rdata;
    logic [15:0] exp_rdata;
    int          exp_fills;
    logic [13:0] exp_fill_addr;
    int          exp_wbs;
    logic [13:0] exp_wb_addr;
    int          wb_off;
    logic [15:0] exp_wb_word;
  } vec_t;

  vec_t vecs [16];
  int   nvec = 0;

  task automatic add(input logic rd, input logic wr, input logic [15:0] addr,
                     input logic [15:0] wdata, input int lat_v, input int stall,
                     input logic crd, input logic [15:0] rdata,
                     input int nf, input logic [13:0] fa,
                     input int nw, input logic [13:0] wa, input int woff,
                     input logic [15:0] ww);
    vecs[nvec].rd            = rd;
    vecs[nvec].wr            = wr;
    vecs[nvec].addr          = addr;
    vecs[nvec].wdata         = wdata;
    vecs[nvec].lat           = lat_v;
    vecs[nvec].exp_stall     = stall;
    vecs[nvec].chk_rdata     = crd;
    vecs[nvec].exp_rdata     = rdata;
    vecs[nvec].exp_fills     = nf;
    vecs[nvec].exp_fill_addr = fa;
    vecs[nvec].exp_wbs       = nw;
    vecs[nvec].exp_wb_addr   = wa;
    vecs[nvec].wb_off        = woff;
    vecs[nvec].exp_wb_word   = ww;
    nvec++;
  endtask

  // Called at a negedge; returns at a negedge with requests dropped.
  task automatic run_vec(input int i);
    int          stalls;
    int          f0;
    int          w0;
    logic [15:0] rd_seen;
    logic [63:0] wword;
    f0        = fill_total;
    w0        = wb_total;
    lat       = vecs[i].lat;
    cpu_rd    = vecs[i].rd;
    cpu_wr    = vecs[i].wr;
    cpu_addr  = vecs[i].addr;
    cpu_wdata = vecs[i].wdata;
    stalls    = 0;
    #1;
    while (cpu_stall && stalls < 200) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    rd_seen = cpu_rdata;
    @(posedge clk);
    @(negedge clk);
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    chk($sformatf("v%0d stall_cycles", i), 64'(stalls), 64'(vecs[i].exp_stall));
    if (vecs[i].chk_rdata)
      chk($sformatf("v%0d rdata", i), 64'(rd_seen), 64'(vecs[i].exp_rdata));
    chk($sformatf("v%0d fills", i), 64'(fill_total - f0), 64'(vecs[i].exp_fills));
    if (vecs[i].exp_fills > 0)
      chk($sformatf("v%0d fill_addr", i), 64'(fill_last_addr), 64'(vecs[i].exp_fill_addr));
    chk($sformatf("v%0d writebacks", i), 64'(wb_total - w0), 64'(vecs[i].exp_wbs));
    if (vecs[i].exp_wbs > 0) begin
      chk($sformatf("v%0d wb_addr", i), 64'(wb_last_addr), 64'(vecs[i].exp_wb_addr));
      wword = wb_last_data >> (16 * vecs[i].wb_off);
      chk($sformatf("v%0d wb_word", i), 64'(wword[15:0]), 64'(vecs[i].exp_wb_word));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //   rd wr addr      wdata     lat stall crd rdata     nf fa        nw wa        off word
    add(1, 0, 16'h0041, 16'h0000, 3, 4, 1, 16'hBBBB, 1, 14'h0010, 0, 14'h0000, 0, 16'h0000); // cold load
    add(0, 1, 16'h0042, 16'h1234, 3, 0, 0, 16'h0000, 0, 14'h0000, 0, 14'h0000, 0, 16'h0000); // store hit
    add(1, 0, 16'h0042, 16'h0000, 3, 0, 1, 16'h1234, 0, 14'h0000, 0, 14'h0000, 0, 16'h0000); // load hit
    add(1, 0, 16'h0142, 16'h0000, 2, 5, 1, 16'h3333, 1, 14'h0050, 1, 14'h0010, 2, 16'h1234); // dirty evict
    add(0, 1, 16'h0203, 16'hBEEF, 1, 2, 0, 16'h0000, 1, 14'h0080, 0, 14'h0000, 0, 16'h0000); // store miss clean
    add(1, 0, 16'h0203, 16'h0000, 1, 0, 1, 16'hBEEF, 0, 14'h0000, 0, 14'h0000, 0, 16'h0000); // merged word
    add(1, 0, 16'h0200, 16'h0000, 1, 0, 1, 16'h5555, 0, 14'h0000, 0, 14'h0000, 0, 16'h0000); // rest of line
    add(1, 0, 16'h0041, 16'h0000, 2, 5, 1, 16'hBBBB, 1, 14'h0010, 1, 14'h0080, 3, 16'hBEEF); // evict store-miss line
    add(1, 0, 16'h0042, 16'h0000, 2, 0, 1, 16'h1234, 0, 14'h0000, 0, 14'h0000, 0, 16'h0000); // refetched written-back word
    add(1, 1, 16'h0040, 16'h7777, 2, 0, 0, 16'h0000, 0, 14'h0000, 0, 14'h0000, 0, 16'h0000); // rd+wr = store
    add(1, 0, 16'h0040, 16'h0000, 2, 0, 1, 16'h7777, 0, 14'h0000, 0, 14'h0000, 0, 16'h0000);
    add(1, 0, 16'h0004, 16'h0000, 1, 2, 1, 16'h1D00, 1, 14'h0001, 0, 14'h0000, 0, 16'h0000); // other index
    // after reset mid-fill
    add(1, 0, 16'h0041, 16'h0000, 2, 3, 1, 16'hBBBB, 1, 14'h0010, 0, 14'h0000, 0, 16'h0000); // misses again
    add(1, 0, 16'h0041, 16'h0000, 2, 0, 1, 16'hBBBB, 0, 14'h0000, 0, 14'h0000, 0, 16'h0000);
    add(1, 0, 16'h0042, 16'h0000, 2, 0, 1, 16'h1234, 0, 14'h0000, 0, 14'h0000, 0, 16'h0000);
    add(0, 1, 16'h0043, 16'h5A5A, 2, 0, 0, 16'h0000, 0, 14'h0000, 0, 14'h0000, 0, 16'h0000);

    rst_n     = 1'b0;
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b0;
    cpu_addr  = 16'h0000;
    cpu_wdata = 16'h0000;
    repeat (3) @(negedge clk);
    #1;
    chk("reset cpu_stall", 64'(cpu_stall), 64'h0);
    chk("reset mem_rd", 64'(mem_rd), 64'h0);
    chk("reset mem_wr", 64'(mem_wr), 64'h0);
    chk("reset cpu_rdata", 64'(cpu_rdata), 64'h0);
`ifdef DCACHE_STATS_EN
    chk("reset hit_cnt", 64'(hit_cnt), 64'h0);
    chk("reset miss_cnt", 64'(miss_cnt), 64'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(i);

    // Reset in the middle of a fill (dirty victim line 0x010 is written back first)
    lat      = 8;
    cpu_rd   = 1'b1;
    cpu_addr = 16'h0142;
    #1;
    for (int k = 0; k < 40 && !mem_rd; k++) begin
      @(negedge clk);
      #1;
    end
    chk("midfill reached FILL", 64'(mem_rd), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("midfill mem_rd async drop", 64'(mem_rd), 64'h0);
    chk("midfill mem_wr", 64'(mem_wr), 64'h0);
    cpu_rd = 1'b0;
    #1;
    chk("midfill cpu_stall", 64'(cpu_stall), 64'h0);
    chk("midfill cpu_rdata", 64'(cpu_rdata), 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 12; i < 16; i++) run_vec(i);

`ifdef DCACHE_STATS_EN
    chk("stats hit_cnt", 64'(hit_cnt), 64'h3);
    chk("stats miss_cnt", 64'(miss_cnt), 64'h1);
    cpu_rd   = 1'b1;
    cpu_addr = 16'h0041;
    repeat (65600) @(posedge clk);
    @(negedge clk);
    cpu_rd = 1'b0;
    #1;
    chk("stats hit_cnt saturated", 64'(hit_cnt), 64'hFFFF);
    chk("stats miss_cnt after hits", 64'(miss_cnt), 64'h1);
`endif

    chk("mem_rd and mem_wr never both high", 64'(both_cnt), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
